arm_exc_seq: RTL and testbench

ARM_EXC_SEQ -- requirements
Module: arm_exc_seq

---
 rtl/arm_exc_seq.sv | 138 +++++++++++++
 tb/tb_arm_exc_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_exc_seq.sv
// ARM exception entry sequencer: picks the highest-priority pending exception,
// then switches mode, saves SPSR/LR in the new bank and loads the vector PC.
module arm_exc_seq #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    BYTES       = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] VECTOR_BASE = '0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [5:0]            Exc_req,
    input  logic                  Exc_is_swi,
    input  logic [DATA_WIDTH-1:0] Exc_pc,
    input  logic [DATA_WIDTH-1:0] CPSR_cur,
    output logic                  Exc_ack,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] CPSR_in,
    output logic                  CPSR_write_en,
    output logic [BYTES-1:0]      CPSR_byte_w_en,
    output logic [DATA_WIDTH-1:0] SPSR_in,
    output logic                  SPSR_write_en,
    output logic [BYTES-1:0]      SPSR_byte_w_en,
    output logic [3:0]            Rd_w_addr,
    output logic [DATA_WIDTH-1:0] Rd_in,
    output logic [BYTES-1:0]      Rd_byte_w_en,
    output logic [DATA_WIDTH-1:0] PC_in,
    output logic                  PC_write_en
);

    typedef enum logic [1:0] {IDLE, MODE, SAVE, VECTOR} state_t;
    typedef enum logic [2:0] {EX_RST, EX_DABT, EX_FIQ, EX_IRQ, EX_PABT, EX_UND, EX_SWI} exc_t;

    state_t                state_q, state_d;
    exc_t                  exc_q, exc_sel;
    logic [DATA_WIDTH-1:0] cpsr_q, pc_q;
    logic [5:0]            req_unmasked;
    logic                  pend;
    logic [4:0]            mode_new;
    logic                  f_new;
    logic [7:0]            vec_off;

    // I and F mask bits are only consulted here, i.e. while IDLE
    assign req_unmasked = Exc_req & ~{2'b00, CPSR_cur[6], CPSR_cur[7], 2'b00};
    assign pend         = |req_unmasked;

    always_comb begin
        exc_sel = Exc_is_swi ? EX_SWI : EX_UND;
        if      (req_unmasked[5]) exc_sel = EX_RST;
        else if (req_unmasked[4]) exc_sel = EX_DABT;
        else if (req_unmasked[3]) exc_sel = EX_FIQ;
        else if (req_unmasked[2]) exc_sel = EX_IRQ;
        else if (req_unmasked[1]) exc_sel = EX_PABT;
    end

    always_comb begin
        mode_new = 5'b10011;
        vec_off  = 8'h00;
        f_new    = cpsr_q[6];
        case (exc_q)
            EX_RST:  begin mode_new = 5'b10011; vec_off = 8'h00; f_new = 1'b1; end
            EX_DABT: begin mode_new = 5'b10111; vec_off = 8'h10; end
            EX_FIQ:  begin mode_new = 5'b10001; vec_off = 8'h1C; f_new = 1'b1; end
            EX_IRQ:  begin mode_new = 5'b10010; vec_off = 8'h18; end
            EX_PABT: begin mode_new = 5'b10111; vec_off = 8'h0C; end
            EX_UND:  begin mode_new = 5'b11011; vec_off = 8'h04; end
            EX_SWI:  begin mode_new = 5'b10011; vec_off = 8'h08; end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            exc_q   <= EX_RST;
            cpsr_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pend) begin
                exc_q  <= exc_sel;
                cpsr_q <= CPSR_cur;
                pc_q   <= Exc_pc;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        Exc_ack        = 1'b0;
        Done           = 1'b0;
        CPSR_in        = '0;
        CPSR_write_en  = 1'b0;
        CPSR_byte_w_en = '0;
        SPSR_in        = '0;
        SPSR_write_en  = 1'b0;
        SPSR_byte_w_en = '0;
        Rd_w_addr      = '0;
        Rd_in          = '0;
        Rd_byte_w_en   = '0;
        PC_in          = '0;
        PC_write_en    = 1'b0;
        case (state_q)
            IDLE: begin
                // ack is combinational, so gate it so nothing escapes during reset
                Exc_ack = pend & Rst;
                if (pend) state_d = MODE;
            end
            MODE: begin
                CPSR_write_en  = 1'b1;
                CPSR_byte_w_en = BYTES'(1);
                CPSR_in        = cpsr_q;
                CPSR_in[7:0]   = {1'b1, f_new, 1'b0, mode_new};
                state_d        = SAVE;
            end
            SAVE: begin
                SPSR_in   = cpsr_q;
                Rd_w_addr = 4'd14;
                Rd_in     = pc_q + DATA_WIDTH'(exc_q == EX_DABT ? 8 : 4);
                if (exc_q != EX_RST) begin
                    SPSR_write_en  = 1'b1;
                    SPSR_byte_w_en = '1;
                    Rd_byte_w_en   = '1;
                end
                state_d = VECTOR;
            end
            VECTOR: begin
                PC_write_en = 1'b1;
                PC_in       = VECTOR_BASE | DATA_WIDTH'(vec_off);
                Done        = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_arm_exc_seq.sv
// Randomised scoreboard bench for arm_exc_seq with directed corner cases up front.
module tb_arm_exc_seq;

    localparam logic [31:0] VB = 32'hFFFF_0000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [5:0]  Exc_req = 6'b111111;
    logic        Exc_is_swi = 1'b0;
    logic [31:0] Exc_pc = '0, CPSR_cur = '0;
    logic        Exc_ack, Busy, Done, CPSR_write_en, SPSR_write_en, PC_write_en;
    logic [31:0] CPSR_in, SPSR_in, Rd_in, PC_in;
    logic [3:0]  CPSR_byte_w_en, SPSR_byte_w_en, Rd_byte_w_en, Rd_w_addr;

    arm_exc_seq #(.DATA_WIDTH(32), .BYTES(4), .VECTOR_BASE(VB)) dut (
        .Clk(Clk), .Rst(Rst), .Exc_req(Exc_req), .Exc_is_swi(Exc_is_swi),
        .Exc_pc(Exc_pc), .CPSR_cur(CPSR_cur), .Exc_ack(Exc_ack), .Busy(Busy),
        .Done(Done), .CPSR_in(CPSR_in), .CPSR_write_en(CPSR_write_en),
        .CPSR_byte_w_en(CPSR_byte_w_en), .SPSR_in(SPSR_in),
        .SPSR_write_en(SPSR_write_en), .SPSR_byte_w_en(SPSR_byte_w_en),
        .Rd_w_addr(Rd_w_addr), .Rd_in(Rd_in), .Rd_byte_w_en(Rd_byte_w_en),
        .PC_in(PC_in), .PC_write_en(PC_write_en)
    );

    always #5 Clk = ~Clk;

    logic any_out;
    assign any_out = |{Exc_ack, Busy, Done, CPSR_in, CPSR_write_en, CPSR_byte_w_en,
                       SPSR_in, SPSR_write_en, SPSR_byte_w_en, Rd_w_addr, Rd_in,
                       Rd_byte_w_en, PC_in, PC_write_en};

    typedef struct {
        int          kind;     // 0 rst,1 dabt,2 fiq,3 irq,4 pabt,5 und,6 swi,-1 none
        logic [31:0] cpsr_in;
        logic        save_en;
        logic [31:0] spsr_in;
        logic [31:0] rd_in;
        logic [31:0] pc_in;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, busy_rem = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: architectural exception-entry rules written as tables
    function automatic exp_t model(input logic [5:0] req, input logic swi,
                                   input logic [31:0] pc, input logic [31:0] cpsr);
        exp_t e;
        logic [5:0] elig;
        logic [4:0] mode;
        logic [7:0] vec;
        logic       f;
        e.kind = -1;
        elig = req;
        if (cpsr[6]) elig[3] = 1'b0;
        if (cpsr[7]) elig[2] = 1'b0;
        for (int b = 5; b >= 0; b--)
            if (e.kind < 0 && elig[b]) e.kind = (b == 0) ? (swi ? 6 : 5) : 5 - b;
        mode = 5'b10011; vec = 8'h00; f = cpsr[6];
        case (e.kind)
            0: begin mode = 5'b10011; vec = 8'h00; f = 1'b1; end
            1: begin mode = 5'b10111; vec = 8'h10; end
            2: begin mode = 5'b10001; vec = 8'h1C; f = 1'b1; end
            3: begin mode = 5'b10010; vec = 8'h18; end
            4: begin mode = 5'b10111; vec = 8'h0C; end
            5: begin mode = 5'b11011; vec = 8'h04; end
            6: begin mode = 5'b10011; vec = 8'h08; end
            default: ;
        endcase
        e.cpsr_in = {cpsr[31:8], 1'b1, f, 1'b0, mode};
        e.save_en = (e.kind != 0);
        e.spsr_in = cpsr;
        e.rd_in   = pc + ((e.kind == 1) ? 32'd8 : 32'd4);
        e.pc_in   = VB | {24'h0, vec};
        return e;
    endfunction

    task automatic cyc(input logic [5:0] req, input logic swi,
                       input logic [31:0] pc, input logic [31:0] cpsr);
        exp_t e;
        @(posedge Clk);
        #2;
        Exc_req = req; Exc_is_swi = swi; Exc_pc = pc; CPSR_cur = cpsr;
        if (busy_rem > 0) busy_rem--;
        else if (Rst) begin
            e = model(req, swi, pc, cpsr);
            if (e.kind >= 0) begin
                q.push_back(e);
                busy_rem = 3;
            end
        end
    endtask

    // Monitor: follows each accepted exception through its three follow-on cycles
    initial begin
        int   phase;
        exp_t cur;
        logic exp_ack;
        phase = 0;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                phase = 0;
                check("reset_outputs_zero", 32'(any_out), 32'd0);
            end else begin
                case (phase)
                    0: begin
                        exp_ack = (q.size() > 0);
                        check("ack", 32'(Exc_ack), 32'(exp_ack));
                        check("idle_busy", 32'(Busy), 32'd0);
                        check("idle_enables", 32'({CPSR_write_en, SPSR_write_en, PC_write_en,
                              Done, CPSR_byte_w_en, SPSR_byte_w_en, Rd_byte_w_en}), 32'd0);
                        if (exp_ack) begin
                            cur = q.pop_front();
                            phase = 1;
                        end
                    end
                    1: begin
                        check("mode_cpsr_we", 32'(CPSR_write_en), 32'd1);
                        check("mode_cpsr_be", 32'(CPSR_byte_w_en), 32'd1);
                        check("mode_cpsr_in", CPSR_in, cur.cpsr_in);
                        check("mode_busy", 32'(Busy), 32'd1);
                        check("mode_others", 32'({SPSR_write_en, PC_write_en, Done, Exc_ack,
                              SPSR_byte_w_en, Rd_byte_w_en}), 32'd0);
                        phase = 2;
                    end
                    2: begin
                        check("save_spsr_we", 32'(SPSR_write_en), 32'(cur.save_en));
                        check("save_spsr_be", 32'(SPSR_byte_w_en), 32'({4{cur.save_en}}));
                        check("save_rd_be", 32'(Rd_byte_w_en), 32'({4{cur.save_en}}));
                        if (cur.save_en) begin
                            check("save_spsr_in", SPSR_in, cur.spsr_in);
                            check("save_rd_addr", 32'(Rd_w_addr), 32'd14);
                            check("save_lr", Rd_in, cur.rd_in);
                        end
                        check("save_others", 32'({CPSR_write_en, PC_write_en, Done, Exc_ack,
                              CPSR_byte_w_en}), 32'd0);
                        phase = 3;
                    end
                    default: begin
                        check("vec_pc_we", 32'(PC_write_en), 32'd1);
                        check("vec_done", 32'(Done), 32'd1);
                        check("vec_pc_in", PC_in, cur.pc_in);
                        check("vec_others", 32'({CPSR_write_en, SPSR_write_en, Exc_ack,
                              CPSR_byte_w_en, SPSR_byte_w_en, Rd_byte_w_en}), 32'd0);
                        phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        logic [5:0]  r;
        logic [31:0] pc;
        #12;
        Exc_req = 6'b000000;
        #1 Rst = 1'b1;

        // IRQ entry
        cyc(6'b000100, 1'b0, 32'h100, 32'h10);
        repeat (3) cyc(6'b000000, 1'b0, 32'h0, 32'h10);
        // Priority: data abort wins, FIQ follows once the abort source drops
        cyc(6'b011100, 1'b0, 32'h2000, 32'h10);
        repeat (3) cyc(6'b001100, 1'b0, 32'h2000, 32'h10);
        cyc(6'b001100, 1'b0, 32'h3000, 32'h10);
        repeat (3) cyc(6'b000000, 1'b0, 32'h0, 32'h10);
        // Masked FIQ and IRQ
        repeat (5) cyc(6'b001100, 1'b0, 32'h400, 32'hD3);
        // Reset exception to high vectors
        cyc(6'b100000, 1'b0, 32'h500, 32'h10);
        repeat (3) cyc(6'b000000, 1'b0, 32'h0, 32'h10);
        // SWI with LR wrap
        cyc(6'b000001, 1'b1, 32'hFFFF_FFFC, 32'h10);
        repeat (3) cyc(6'b000000, 1'b0, 32'h0, 32'h10);
        // Undefined and prefetch abort
        cyc(6'b000001, 1'b0, 32'h600, 32'h1F);
        repeat (3) cyc(6'b000000, 1'b0, 32'h0, 32'h10);
        cyc(6'b000010, 1'b0, 32'h700, 32'h13);
        repeat (3) cyc(6'b000000, 1'b0, 32'h0, 32'h10);

        // Async reset in the SAVE cycle
        cyc(6'b000100, 1'b0, 32'h800, 32'h10);
        repeat (2) cyc(6'b000000, 1'b0, 32'h0, 32'h10);
        #1 Rst = 1'b0;
        #1 check("async_reset_in_save", 32'(any_out), 32'd0);
        q.delete();
        busy_rem = 0;
        repeat (2) @(posedge Clk);
        #3 Rst = 1'b1;
        repeat (2) cyc(6'b000000, 1'b0, 32'h0, 32'h10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 6; b++) r[b] = ($urandom_range(0, 5) == 0);
            pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            cyc(r, 1'($urandom_range(0, 1)), pc, $urandom);
        end
        repeat (6) cyc(6'b000000, 1'b0, 32'h0, 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
